pwm_duty_gen: RTL
=================

# pwm_duty_gen

Duty-cycle register and PWM waveform generator directly downstream of the up/down control FSM. Consumes the FSM's 2-bit `sel` command (hold / increment / decrement), keeps a saturating duty value in percent (0..100), returns it as `duty` for the FSM's limit checks, and produces a glitch-free PWM output. The PWM period is 100 phase steps, and a programmable prescaler sets the step rate.

## Interface
- `DUTY_MAX`, default 100: upper saturation limit for the duty value, and the number of phase steps per PWM period.
- `DUTY_W`, default 7: width of the duty value and of the phase counter.
- `PRESC_W`, default 16: width of the prescaler reload value and of the prescaler counter.

Ports:
- `clk`  in  1  System clock. All flops update on the rising edge.
- `rst_n`  in  1  Reset, asynchronous, active-low.
- `ena`  in  1  Enable, active high. When low, all state freezes.
- `sel`  in  2  Command from the FSM: 00 hold, 01 increment, 10 decrement, 11 hold.
- `presc`  in  PRESC_W  Prescaler reload value. One phase step occurs every `presc+1` enabled cycles.
- `duty`  out  DUTY_W  Commanded duty in percent. This is the value the FSM receives as `Y`.
- `pwm_out`  out  1  Registered PWM waveform.
- `period_end`  out  1  One-cycle pulse when the phase counter wraps.

## Operation
- **Reset:** `duty`=0, active duty=0, prescaler count=0, phase=0, `pwm_out`=0, `period_end`=0.
- **Duty register** (only while `ena`=1):
  - `sel`=01 and `duty`<DUTY_MAX: `duty`+1.
  - `sel`=10 and `duty`>0: `duty`-1.
  - Otherwise `duty` is held.
  - Saturation is silent: no wrap at 0 or at DUTY_MAX.
- **Prescaler:**
  - The counter increments on every enabled cycle.
  - When count >= `presc`: assert the internal `tick` and reload the count to 0.
  - `presc`=0 gives a tick on every enabled cycle.
  - A `presc` value lowered below the current count takes effect on the next enabled cycle, with an immediate tick.
- **Phase counter:**
  - Advances on `tick` and runs 0..DUTY_MAX-1.
  - On `tick` at DUTY_MAX-1 it wraps to 0 and asserts `period_end` for one cycle.
- **Active duty:**
  - The comparison value used by the PWM compare.
  - Loaded from `duty` on the wrap tick (see Configuration).
- **PWM compare:** `pwm_out` <= (phase < active duty).
  - Active duty 0: `pwm_out` stays constant low.
  - Active duty DUTY_MAX: `pwm_out` stays constant high.
- **`ena`=0:**
  - Prescaler, phase, `duty` and active duty all hold.
  - `pwm_out` holds its last value.
  - `period_end` is 0.
- **Arithmetic:** unsigned throughout. Compare widths match DUTY_W; no truncation is possible while DUTY_MAX <= 2^DUTY_W - 1.

## Timing
- **`sel` to `duty`:** `sel` is sampled on edge N and `duty` reflects it after edge N. The FSM holds each inc/dec code for exactly one cycle, which gives exactly one step per press.
- **Phase to `pwm_out`:** 1-cycle latency, because `pwm_out` is registered.
- **`period_end`:** asserted in the cycle after the wrap edge, together with phase=0.
- **Period length:** DUTY_MAX × (`presc`+1) enabled cycles.
- **Reset mid-period:** asynchronous clear of all outputs. Counting restarts at phase 0 on the first enabled edge after `rst_n` rises.
- **Simultaneous events:**
  - `sel` step on the same edge as the wrap tick: the active duty latches the pre-step `duty`, and the new value applies from the next period.
  - `sel`=11: treated as hold.

## Configuration
- **`PWM_SHADOW_EN` defined:** active duty is a shadow register loaded only on the wrap tick. Duty changes never alter the current period, so there are no runt pulses.
- **`PWM_SHADOW_EN` undefined:**
  - Active duty is `duty` directly.
  - A change takes effect on the next compare, one cycle after the `duty` update.
  - The current period may be truncated or extended.

## Test plan
- **Reset and first period:** `presc`=0, `sel`=00, release `rst_n` -> `duty`=0, `pwm_out` stays 0, `period_end` pulses every 100 cycles.
- **Increment to saturation:** 105 single-cycle `sel`=01 pulses -> `duty` reads 100 and stays 100; after the next wrap, `pwm_out` is constantly 1.
- **Decrement floor:** from `duty`=2, three `sel`=10 pulses -> 1, 0, 0.
- **Duty 30, `presc`=3:**
  - Period = 400 cycles with `pwm_out` high for 120 cycles.
  - `period_end` is spaced by 400 cycles.
- **Shadow check:** `duty` 50 -> 20 mid-period, with `presc`=0.
  - With `PWM_SHADOW_EN`: the current period keeps 50 high cycles and the next period has 20.
  - Without it: `pwm_out` falls within 2 cycles once phase >= 20.
- **`ena` and reset abuse:**
  - Drop `ena` for 10 cycles mid-period -> phase and `pwm_out` frozen, and the period is lengthened by 10.
  - Assert `rst_n`=0 asynchronously mid-high -> `pwm_out` goes to 0 immediately without waiting for a clock edge, and `duty`=0.

Source files
------------

// File: rtl/pwm_duty_gen.sv
// rtl/pwm_duty_gen.sv - saturating duty register and prescaled PWM generator
// Build option PWM_SHADOW_EN: the active duty is shadowed and reloaded only at period wrap.
module pwm_duty_gen #(
    parameter int unsigned DUTY_MAX = 100,
    parameter int unsigned DUTY_W   = 7,
    parameter int unsigned PRESC_W  = 16
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_ena,
    input  logic [1:0]         i_sel,
    input  logic [PRESC_W-1:0] i_presc,
    output logic [DUTY_W-1:0]  o_duty,
    output logic               o_pwm_out,
    output logic               o_period_end
);

    localparam logic [1:0]        SEL_INC      = 2'b01;
    localparam logic [1:0]        SEL_DEC      = 2'b10;
    localparam logic [DUTY_W-1:0] W_DUTY_MAX   = DUTY_W'(DUTY_MAX);
    localparam logic [DUTY_W-1:0] W_PHASE_LAST = DUTY_W'(DUTY_MAX - 1);

    logic [DUTY_W-1:0]  r_duty;
    logic [DUTY_W-1:0]  r_phase;
    logic [PRESC_W-1:0] r_presc_cnt;
    logic               r_pwm;
    logic               r_period_end;

    logic [DUTY_W-1:0]  w_duty_next;
    logic [DUTY_W-1:0]  w_phase_next;
    logic [DUTY_W-1:0]  w_active;
    logic               w_tick;
    logic               w_wrap;

    always_comb begin
        w_duty_next = r_duty;
        case (i_sel)
            SEL_INC: if (r_duty < W_DUTY_MAX) w_duty_next = r_duty + 1'b1;
            SEL_DEC: if (r_duty != '0)        w_duty_next = r_duty - 1'b1;
            default: w_duty_next = r_duty;
        endcase
    end

    // ">=" rather than "==" so a reload value lowered below the running count ticks at once
    assign w_tick       = i_ena && (r_presc_cnt >= i_presc);
    assign w_wrap       = w_tick && (r_phase == W_PHASE_LAST);
    assign w_phase_next = w_wrap ? '0 : r_phase + 1'b1;

`ifdef PWM_SHADOW_EN
    logic [DUTY_W-1:0] r_active;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_active <= '0;
        end else if (w_wrap) begin
            r_active <= r_duty;
        end
    end

    assign w_active = r_active;
`else
    assign w_active = r_duty;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_duty       <= '0;
            r_phase      <= '0;
            r_presc_cnt  <= '0;
            r_pwm        <= 1'b0;
            r_period_end <= 1'b0;
        end else if (i_ena) begin
            r_duty       <= w_duty_next;
            r_presc_cnt  <= w_tick ? '0 : r_presc_cnt + 1'b1;
            r_pwm        <= (r_phase < w_active);
            r_period_end <= w_wrap;
            if (w_tick) begin
                r_phase <= w_phase_next;
            end
        end else begin
            r_period_end <= 1'b0;
        end
    end

    assign o_duty       = r_duty;
    assign o_pwm_out    = r_pwm;
    assign o_period_end = r_period_end;

endmodule
